// File: rtl/cdu_pkg.sv
// Shared types and helpers for the CDU read counter bank.
package cdu_pkg;

    typedef enum logic {
        IDLE,
        OFFER
    } cdu_state_e;

    localparam logic DIR_PLUS  = 1'b0;
    localparam logic DIR_MINUS = 1'b1;

    // Backlog range is symmetric, so the most negative code is never used.
    function automatic int pend_limit(input int pend_w);
        return (1 << (pend_w - 1)) - 1;
    endfunction

    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/cdu_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant_i, wrapping modulo NCH.
module cdu_rr_arbiter
    import cdu_pkg::*;
#(
    parameter int NCH  = 5,
    parameter int CH_W = 3
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [CH_W-1:0] last_grant_i,
    output logic [CH_W-1:0] grant_o,
    output logic            any_req_o
);

    logic [CH_W-1:0] idx;

    always_comb begin
        grant_o   = '0;
        any_req_o = 1'b0;
        idx       = '0;
        for (int i = 1; i <= NCH; i++) begin
            if (int'(last_grant_i) + i >= NCH) begin
                idx = CH_W'(int'(last_grant_i) + i - NCH);
            end else begin
                idx = CH_W'(int'(last_grant_i) + i);
            end
            if (!any_req_o && req_i[idx]) begin
                any_req_o = 1'b1;
                grant_o   = idx;
            end
        end
    end

endmodule

// File: rtl/cdu_read_counter_bank.sv
// Multi-channel CDU read counter: wrap-around angles, signed report backlogs and a
// round-robin valid/ready pulse link draining the backlogs one count at a time.
module cdu_read_counter_bank
    import cdu_pkg::*;
#(
    parameter int NCH    = 5,
    parameter int WIDTH  = 16,
    parameter int PEND_W = 4,
    localparam int CH_W  = ch_width(NCH)
) (
    input  logic                 CLOCKH,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       up,
    input  logic [NCH-1:0]       dn,
    input  logic [NCH-1:0]       zero,
    output logic [NCH*WIDTH-1:0] angle,
    output logic                 out_valid,
    output logic [CH_W-1:0]      out_ch,
    output logic                 out_dir,
    input  logic                 out_ready,
    output logic [NCH-1:0]       ovf,
    input  logic [NCH-1:0]       clr_ovf
);

    localparam int LIM = pend_limit(PEND_W);
    localparam int SW  = PEND_W + 2;
    localparam logic signed [SW-1:0] LIM_P = SW'(LIM);
    localparam logic signed [SW-1:0] LIM_N = SW'(-LIM);

    cdu_state_e      state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic [CH_W-1:0] last_q, last_d;
    logic            dir_q, dir_d;
    logic [CH_W-1:0] grant;
    logic            any_req;
    logic            accept;
    logic [NCH-1:0]  req;
    logic [NCH-1:0]  pend_neg;

    // A zero on the offered channel overrides acceptance and withdraws the offer.
    assign accept = (state_q == OFFER) && out_ready && !zero[ch_q];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [WIDTH-1:0]         ang_q, ang_d;
        logic signed [PEND_W-1:0] pend_q, pend_d;
        logic                     ovf_q, ovf_d;
        logic signed [SW-1:0]     delta;
        logic signed [SW-1:0]     sum;
        logic                     sat;

        always_comb begin
            delta = '0;
            ang_d = ang_q;
            if (up[c] && !dn[c]) begin
                delta = delta + SW'(1);
                ang_d = ang_q + WIDTH'(1);
            end else if (dn[c] && !up[c]) begin
                delta = delta - SW'(1);
                ang_d = ang_q - WIDTH'(1);
            end
            // Acceptance is summed with the same-cycle increment before clamping.
            if (accept && (ch_q == CH_W'(c))) begin
                delta = (dir_q == DIR_PLUS) ? delta - SW'(1) : delta + SW'(1);
            end
            sum    = SW'(pend_q) + delta;
            sat    = 1'b0;
            pend_d = PEND_W'(sum);
            if (sum > LIM_P) begin
                pend_d = PEND_W'(LIM_P);
                sat    = 1'b1;
            end else if (sum < LIM_N) begin
                pend_d = PEND_W'(LIM_N);
                sat    = 1'b1;
            end
            if (zero[c]) begin
                ang_d  = '0;
                pend_d = '0;
                sat    = 1'b0;
            end
            ovf_d = sat ? 1'b1 : (clr_ovf[c] ? 1'b0 : ovf_q);
        end

        always_ff @(posedge CLOCKH or negedge rst_n) begin
            if (!rst_n) begin
                ang_q  <= '0;
                pend_q <= '0;
                ovf_q  <= 1'b0;
            end else begin
                ang_q  <= ang_d;
                pend_q <= pend_d;
                ovf_q  <= ovf_d;
            end
        end

        assign angle[c*WIDTH +: WIDTH] = ang_q;
        assign ovf[c]      = ovf_q;
        assign req[c]      = (pend_q != '0) && !zero[c];
        assign pend_neg[c] = pend_q[PEND_W-1];
    end

    cdu_rr_arbiter #(
        .NCH  (NCH),
        .CH_W (CH_W)
    ) u_arb (
        .req_i        (req),
        .last_grant_i (last_q),
        .grant_o      (grant),
        .any_req_o    (any_req)
    );

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        dir_d   = dir_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    ch_d    = grant;
                    dir_d   = pend_neg[grant] ? DIR_MINUS : DIR_PLUS;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (zero[ch_q]) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    last_d  = ch_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCKH or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            dir_q   <= DIR_PLUS;
            last_q  <= CH_W'(NCH - 1);
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            dir_q   <= dir_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = (state_q == OFFER);
    assign out_ch    = ch_q;
    assign out_dir   = dir_q;

endmodule

// File: tb/tb_cdu_read_counter_bank.sv
// Directed bench for cdu_read_counter_bank: angles, backlog drain, saturation, arbitration, zeroing.
module tb_cdu_read_counter_bank;

    localparam int NCH    = 5;
    localparam int WIDTH  = 16;
    localparam int PEND_W = 4;
    localparam int CH_W   = 3;

    logic                 CLOCKH;
    logic                 rst_n;
    logic [NCH-1:0]       up, dn, zero, clr_ovf;
    logic [NCH*WIDTH-1:0] angle;
    logic                 out_valid;
    logic [CH_W-1:0]      out_ch;
    logic                 out_dir;
    logic                 out_ready;
    logic [NCH-1:0]       ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;
    int pq_ch[$];
    int pq_dir[$];
    int pq_cyc[$];

    cdu_read_counter_bank #(
        .NCH    (NCH),
        .WIDTH  (WIDTH),
        .PEND_W (PEND_W)
    ) dut (
        .CLOCKH    (CLOCKH),
        .rst_n     (rst_n),
        .up        (up),
        .dn        (dn),
        .zero      (zero),
        .angle     (angle),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_dir   (out_dir),
        .out_ready (out_ready),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    initial begin
        CLOCKH = 1'b0;
        forever #5 CLOCKH = ~CLOCKH;
    end

    // Records every accepted pulse with the cycle it was taken on.
    always @(posedge CLOCKH) begin
        if (rst_n && out_valid && out_ready) begin
            pq_ch.push_back(int'(out_ch));
            pq_dir.push_back(int'(out_dir));
            pq_cyc.push_back(cyc_cnt);
        end
        cyc_cnt <= cyc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ang(input int c);
        return angle[c*WIDTH +: WIDTH];
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCKH);
    endtask

    task automatic strobe(input logic [NCH-1:0] u, input logic [NCH-1:0] d, input logic [NCH-1:0] z);
        up = u; dn = d; zero = z;
        @(negedge CLOCKH);
        up = '0; dn = '0; zero = '0;
    endtask

    task automatic clear_pulses();
        pq_ch.delete(); pq_dir.delete(); pq_cyc.delete();
    endtask

    task automatic chk_pulses(input string tag, input int exp_ch[$], input int exp_dir[$]);
        chk($sformatf("%s_count", tag), pq_ch.size(), exp_ch.size());
        for (int i = 0; i < exp_ch.size() && i < pq_ch.size(); i++) begin
            chk($sformatf("%s_ch%0d", tag, i), pq_ch[i], exp_ch[i]);
            chk($sformatf("%s_dir%0d", tag, i), pq_dir[i], exp_dir[i]);
        end
    endtask

    initial begin
        rst_n = 1'b0; up = '0; dn = '0; zero = '0; clr_ovf = '0; out_ready = 1'b0;
        cyc(3);
        chk("rst_angle", angle[31:0], 32'h0);
        chk("rst_angle_hi", {16'h0, angle[79:64]}, 32'h0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_dir", out_dir, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        cyc(1);

        // Three ups on ch2, link always ready: pulses every other cycle.
        out_ready = 1'b1;
        clear_pulses();
        for (int i = 0; i < 3; i++) strobe(5'b00100, '0, '0);
        cyc(12);
        chk("t2_angle2", ang(2), 3);
        chk_pulses("t2", '{2, 2, 2}, '{0, 0, 0});
        if (pq_cyc.size() == 3) begin
            chk("t2_gap01", pq_cyc[1] - pq_cyc[0], 2);
            chk("t2_gap12", pq_cyc[2] - pq_cyc[1], 2);
        end
        chk("t2_idle", out_valid, 0);

        // Wrap both ways on ch0.
        clear_pulses();
        strobe(5'b00000, 5'b00001, '0);
        cyc(6);
        chk("t3_wrap_dn", ang(0), 16'hFFFF);
        strobe(5'b00001, 5'b00000, '0);
        cyc(6);
        chk("t3_wrap_up", ang(0), 16'h0000);
        chk("t3_ovf0", ovf[0], 0);
        strobe(5'b00000, 5'b00001, '0);
        cyc(6);
        chk("t3_wrap_dn2", ang(0), 16'hFFFF);
        chk_pulses("t3", '{0, 0, 0}, '{1, 0, 1});

        // Saturation on ch1 with the link stalled.
        out_ready = 1'b0;
        clear_pulses();
        for (int i = 0; i < 8; i++) strobe(5'b00010, '0, '0);
        cyc(2);
        chk("t4_angle1", ang(1), 8);
        chk("t4_ovf1", ovf[1], 1);
        chk("t4_ovf_others", {ovf[4:2], ovf[0]}, 0);
        chk("t4_hold_valid", out_valid, 1);
        chk("t4_hold_ch", out_ch, 1);
        out_ready = 1'b1;
        cyc(20);
        chk_pulses("t4", '{1, 1, 1, 1, 1, 1, 1}, '{0, 0, 0, 0, 0, 0, 0});
        chk("t4_ovf_sticky", ovf[1], 1);
        clr_ovf = 5'b00010;
        cyc(1);
        clr_ovf = '0;
        chk("t4_ovf_clr", ovf[1], 0);

        // Round-robin order; first make ch4 the last grant.
        strobe(5'b10000, '0, '0);
        cyc(6);
        clear_pulses();
        strobe(5'b10011, '0, '0);
        cyc(12);
        chk_pulses("t5a", '{0, 1, 4}, '{0, 0, 0});
        clear_pulses();
        strobe(5'b10011, '0, '0);
        cyc(2);
        strobe(5'b00001, '0, '0);
        cyc(14);
        chk_pulses("t5b", '{0, 1, 4, 0}, '{0, 0, 0, 0});

        // Backlog reverses sign while a plus offer on ch3 is outstanding.
        out_ready = 1'b0;
        clear_pulses();
        strobe(5'b01000, '0, '0);
        cyc(3);
        chk("t6_valid", out_valid, 1);
        chk("t6_ch", out_ch, 3);
        chk("t6_dir", out_dir, 0);
        strobe('0, 5'b01000, '0);
        strobe('0, 5'b01000, '0);
        chk("t6_stable_dir", out_dir, 0);
        out_ready = 1'b1;
        cyc(12);
        chk_pulses("t6", '{3, 3, 3}, '{0, 1, 1});
        chk("t6_angle3", ang(3), 16'hFFFF);

        // Zero withdraws the offer on ch3.
        out_ready = 1'b0;
        clear_pulses();
        strobe(5'b01000, '0, '0);
        strobe(5'b01000, '0, '0);
        cyc(2);
        chk("t7_pre_angle3", ang(3), 1);
        chk("t7_pre_valid", out_valid, 1);
        strobe('0, '0, 5'b01000);
        chk("t7_valid_drop", out_valid, 0);
        chk("t7_angle3", ang(3), 0);
        out_ready = 1'b1;
        cyc(10);
        chk_pulses("t7", '{}, '{});
        chk("t7_idle", out_valid, 0);

        // Asynchronous reset mid-offer.
        out_ready = 1'b0;
        strobe(5'b00100, '0, '0);
        cyc(3);
        chk("t8_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t8_async_valid", out_valid, 0);
        chk("t8_async_angle2", ang(2), 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
